// File: rtl/intarb_pkg.sv
// Shared types and constants for the interrupt arbiter.
package intarb_pkg;

  localparam int unsigned VEC_W  = 8;
  localparam int unsigned BUSD_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SACK,
    INTR,
    DONE
  } state_t;

endpackage

// File: rtl/intarb_prio.sv
// Fixed-priority encoder: the lowest-index asserted request wins.
module intarb_prio #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] intreqs,
  output logic            valid,
  output logic [IDXW-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last to be assigned.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = NREQ; i > 0; i--) begin
      if (intreqs[i-1]) begin
        valid = 1'b1;
        idx   = IDXW'(i - 1);
      end
    end
  end

endmodule

// File: rtl/intarb.sv
// Interrupt arbiter for one bus request level: requests the bus, takes the
// grant, acquires bus mastership and delivers the winning device's vector.
// Optional feature: define INTARB_TIMEOUT_EN to abandon a vector transfer
// when SSYN does not arrive within TMOCYC cycles.
module intarb
  import intarb_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned TMOCYC = 1000
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic [NREQ-1:0]       intreqs,
  input  logic [VEC_W*NREQ-1:0] irvecs,
  output logic                  intgnt,
  output logic [VEC_W-1:0]      igvec,
  output logic                  bus_br_out,
  input  logic                  bus_bg_in,
  output logic                  bus_bg_out,
  output logic                  bus_sack_out,
  input  logic                  bus_bbsy_in,
  output logic                  bus_bbsy_out,
  output logic                  bus_intr_out,
  input  logic                  bus_ssyn_in,
  output logic [BUSD_W-1:0]     bus_d_out
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t             state;
  state_t             state_nxt;
  logic               pvalid;
  logic [IDXW-1:0]    pidx;
  logic [VEC_W-1:0]   pvec;
  logic [VEC_W-1:0]   lat_vec;
  logic               gnt_q;
  logic [VEC_W-1:0]   igvec_q;
  logic               tmo_hit;

  intarb_prio #(
    .NREQ (NREQ)
  ) u_prio (
    .intreqs (intreqs),
    .valid   (pvalid),
    .idx     (pidx)
  );

  // Vector of the current winner; only sampled at the REQ-to-SACK step.
  always_comb begin
    pvec = irvecs[VEC_W*pidx +: VEC_W];
  end

`ifdef INTARB_TIMEOUT_EN
  localparam int unsigned CNTW = $clog2(TMOCYC + 1);

  logic [CNTW-1:0] tmo_cnt;

  // Cycle counter that runs only while in INTR and restarts on every entry.
  always_ff @(posedge CLOCK) begin
    if (RESET || state != INTR) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_comb begin
    tmo_hit = (tmo_cnt == CNTW'(TMOCYC - 1));
  end
`else
  always_comb begin
    tmo_hit = 1'b0;
  end
`endif

  // State register, frozen vector and the one-cycle grant pulse.
  // The device index is consumed at latch time; only its vector is kept.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state   <= IDLE;
      lat_vec <= '0;
      gnt_q   <= 1'b0;
      igvec_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == REQ && state_nxt == SACK) begin
        lat_vec <= pvec;
      end
      gnt_q <= (state == INTR && state_nxt == DONE);
      if (state == INTR && state_nxt == DONE) begin
        igvec_q <= lat_vec;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (pvalid && !bus_bg_in)        state_nxt = REQ;
      REQ: begin
        if (!pvalid)                         state_nxt = IDLE;
        else if (bus_bg_in)                  state_nxt = SACK;
      end
      SACK: if (!bus_bg_in && !bus_bbsy_in)  state_nxt = INTR;
      INTR: begin
        if (bus_ssyn_in)                     state_nxt = DONE;
        else if (tmo_hit)                    state_nxt = IDLE;
      end
      DONE: if (!bus_ssyn_in)                state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  // Bus drives decoded from state; the grant passes through unless this
  // level is requesting with a live request or holding the selection.
  always_comb begin
    bus_br_out   = 1'b0;
    bus_bg_out   = bus_bg_in;
    bus_sack_out = 1'b0;
    bus_bbsy_out = 1'b0;
    bus_intr_out = 1'b0;
    bus_d_out    = '0;
    unique case (state)
      REQ: begin
        bus_br_out = 1'b1;
        bus_bg_out = bus_bg_in & ~pvalid;
      end
      SACK: begin
        bus_bg_out   = 1'b0;
        bus_sack_out = 1'b1;
      end
      INTR: begin
        bus_bbsy_out = 1'b1;
        bus_intr_out = 1'b1;
        bus_d_out    = {{(BUSD_W-VEC_W){1'b0}}, lat_vec};
      end
      default: ;
    endcase
  end

  always_comb begin
    intgnt = gnt_q;
    igvec  = igvec_q;
  end

endmodule

// File: tb/tb_intarb.sv
// Self-checking bench for intarb: fixed vector table, hand-written corner
// sequences and randomized transfers against a priority/vector model.
module tb_intarb;

  localparam int unsigned NREQ = 4;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [3:0]  intreqs;
  logic [31:0] irvecs;
  logic        intgnt;
  logic [7:0]  igvec;
  logic        bus_br_out;
  logic        bus_bg_in;
  logic        bus_bg_out;
  logic        bus_sack_out;
  logic        bus_bbsy_in;
  logic        bus_bbsy_out;
  logic        bus_intr_out;
  logic        bus_ssyn_in;
  logic [15:0] bus_d_out;

  int n_cmp = 0;
  int n_err = 0;

  intarb #(
    .NREQ   (NREQ),
    .TMOCYC (16)
  ) dut (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .intreqs      (intreqs),
    .irvecs       (irvecs),
    .intgnt       (intgnt),
    .igvec        (igvec),
    .bus_br_out   (bus_br_out),
    .bus_bg_in    (bus_bg_in),
    .bus_bg_out   (bus_bg_out),
    .bus_sack_out (bus_sack_out),
    .bus_bbsy_in  (bus_bbsy_in),
    .bus_bbsy_out (bus_bbsy_out),
    .bus_intr_out (bus_intr_out),
    .bus_ssyn_in  (bus_ssyn_in),
    .bus_d_out    (bus_d_out)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  reqs;
    logic [31:0] vecs;
    logic [7:0]  expv;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK);
  endtask

  // Lowest set request wins; its byte of the vector bus is delivered.
  function automatic logic [7:0] model_vec(input logic [3:0] reqs, input logic [31:0] vecs);
    for (int i = 0; i < NREQ; i++) begin
      if (reqs[i]) return vecs[8*i +: 8];
    end
    return 8'h00;
  endfunction

  task automatic chk_quiet(input string name);
    chk({name, "_br"},   bus_br_out,   0);
    chk({name, "_sack"}, bus_sack_out, 0);
    chk({name, "_bbsy"}, bus_bbsy_out, 0);
    chk({name, "_intr"}, bus_intr_out, 0);
    chk({name, "_d"},    bus_d_out,    0);
    chk({name, "_gnt"},  intgnt,       0);
  endtask

  // Raise requests, run BR/BG/SACK handshake and stop with the DUT in INTR.
  // While in SACK the requests and vectors are disturbed to prove the latch.
  task automatic to_intr(input logic [3:0] reqs, input logic [31:0] vecs,
                         input logic [3:0] perturb, output bit ok);
    intreqs     = reqs;
    irvecs      = vecs;
    bus_bg_in   = 1'b0;
    bus_bbsy_in = 1'b0;
    bus_ssyn_in = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick();
      if (bus_br_out) ok = 1'b1;
    end
    chk("br_wait", ok, 1);
    if (!ok) return;
    chk("req_bg_out", bus_bg_out, 0);
    bus_bg_in = 1'b1;
    tick();
    chk("sack_sack", bus_sack_out, 1);
    chk("sack_br",   bus_br_out,   0);
    chk("sack_bgo",  bus_bg_out,   0);
    intreqs     = perturb;
    irvecs      = ~vecs;
    bus_bg_in   = 1'b0;
    bus_bbsy_in = 1'b1;
    tick();
    chk("sack_hold_bbsy", bus_sack_out, 1);
    chk("sack_hold_intr", bus_intr_out, 0);
    bus_bbsy_in = 1'b0;
    tick();
    chk("intr_intr", bus_intr_out, 1);
    chk("intr_bbsy", bus_bbsy_out, 1);
    chk("intr_sack", bus_sack_out, 0);
  endtask

  // From INTR: check data, complete SSYN, check the grant pulse, back to IDLE.
  task automatic finish_xfer(input logic [7:0] expv, input logic [3:0] next_reqs);
    chk("intr_d", bus_d_out, {8'h00, expv});
    bus_ssyn_in = 1'b1;
    tick();
    chk("done_gnt",   intgnt,       1);
    chk("done_igvec", igvec,        expv);
    chk("done_intr",  bus_intr_out, 0);
    chk("done_bbsy",  bus_bbsy_out, 0);
    chk("done_d",     bus_d_out,    0);
    tick();
    chk("done_gnt_once", intgnt, 0);
    bus_ssyn_in = 1'b0;
    intreqs     = next_reqs;
    tick();
    chk("idle_br",  bus_br_out, 0);
    chk("idle_gnt", intgnt,     0);
  endtask

  initial begin
    bit          ok;
    logic [3:0]  r;
    logic [3:0]  p;
    logic [31:0] v;

    tbl[0] = '{4'b0100, 32'h0030_0000, 8'o060};
    tbl[1] = '{4'b0001, 32'h4433_2211, 8'h11};
    tbl[2] = '{4'b1000, 32'h4433_2211, 8'h44};
    tbl[3] = '{4'b1111, 32'hAABB_CCDD, 8'hDD};
    tbl[4] = '{4'b0110, 32'hAABB_CCDD, 8'hCC};
    tbl[5] = '{4'b1100, 32'h0102_0304, 8'h02};

    RESET       = 1'b1;
    intreqs     = '0;
    irvecs      = '0;
    bus_bg_in   = 1'b0;
    bus_bbsy_in = 1'b0;
    bus_ssyn_in = 1'b0;
    repeat (3) tick();
    chk_quiet("reset");
    chk("reset_igvec", igvec, 0);
    chk("reset_bgo", bus_bg_out, 0);
    RESET = 1'b0;
    tick();
    chk_quiet("post_reset");

    // Grant passes straight through an idle level with no requests.
    bus_bg_in = 1'b1;
    #1;
    chk("idle_bg_pass", bus_bg_out, 1);
    chk("idle_bg_br",   bus_br_out, 0);
    tick();
    chk("idle_bg_br2",  bus_br_out, 0);

    // A request arriving during a foreign grant waits for it to drop.
    intreqs = 4'b0001;
    tick();
    tick();
    chk("req_wait_bg", bus_br_out, 0);
    bus_bg_in = 1'b0;
    tick();
    chk("req_after_bg", bus_br_out, 1);

    // Request withdrawn before grant: BR drops.
    intreqs = 4'b0000;
    tick();
    chk("withdraw_br", bus_br_out, 0);

    // Grant arriving in REQ after the request vanished is passed downstream.
    intreqs = 4'b0001;
    tick();
    chk("req_again", bus_br_out, 1);
    intreqs   = 4'b0000;
    bus_bg_in = 1'b1;
    #1;
    chk("req_nogo_bgo", bus_bg_out, 1);
    tick();
    chk("req_nogo_br",   bus_br_out,   0);
    chk("req_nogo_sack", bus_sack_out, 0);
    bus_bg_in = 1'b0;
    tick();

    // Fixed table of request/vector patterns.
    for (int k = 0; k < 6; k++) begin
      to_intr(tbl[k].reqs, tbl[k].vecs, 4'b0000, ok);
      if (ok) finish_xfer(tbl[k].expv, 4'b0000);
      tick();
    end

    // Two pending requests are served in priority order.
    to_intr(4'b1010, 32'h3344_5566, 4'b1010, ok);
    if (ok) finish_xfer(8'h55, 4'b1000);
    to_intr(4'b1000, 32'h3344_5566, 4'b1000, ok);
    if (ok) finish_xfer(8'h33, 4'b0000);
    tick();

    // Randomized transfers against the model.
    for (int k = 0; k < 24; k++) begin
      r = 4'($urandom_range(1, 15));
      v = $urandom;
      p = 4'($urandom_range(0, 15));
      to_intr(r, v, p, ok);
      if (ok) finish_xfer(model_vec(r, v), 4'b0000);
      tick();
    end

    // Reset in INTR abandons the transfer without a grant pulse.
    to_intr(4'b0010, 32'h0000_7700, 4'b0010, ok);
    RESET = 1'b1;
    tick();
    chk_quiet("rst_intr");
    chk("rst_intr_igvec", igvec, 0);
    chk("rst_intr_bgo", bus_bg_out, 0);
    RESET   = 1'b0;
    intreqs = 4'b0000;
    tick();
    chk("rst_intr_gnt", intgnt, 0);

`ifdef INTARB_TIMEOUT_EN
    begin
      int cyc;
      bit back;
      to_intr(4'b0001, 32'h0000_005A, 4'b0001, ok);
      cyc = 1;
      for (int i = 0; i < 40; i++) begin
        tick();
        chk("tmo_no_gnt", intgnt, 0);
        if (!bus_intr_out) break;
        cyc++;
      end
      chk("tmo_cycles", cyc, 16);
      chk("tmo_bbsy", bus_bbsy_out, 0);
      chk("tmo_d",    bus_d_out,    0);
      back = 1'b0;
      for (int i = 0; i < 4 && !back; i++) begin
        tick();
        if (bus_br_out) back = 1'b1;
      end
      chk("tmo_retry_br", back, 1);
      intreqs = 4'b0000;
      tick();
      tick();
    end
`else
    to_intr(4'b0001, 32'h0000_005A, 4'b0001, ok);
    repeat (40) tick();
    chk("hold_intr", bus_intr_out, 1);
    chk("hold_gnt",  intgnt,       0);
    if (ok) finish_xfer(8'h5A, 4'b0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
